hu_spi_responder: RTL

SPI slave (responder) that lets an SPI master drive a 16-register local bus through SPICLK, MOSI, nSPICS and MISO, clocked from the 7 MHz system clock. It is the far end of the HULOGIC SPI master link, used on peripheral FPGAs and as the bench responder for the HULOGIC FPGA. SPI inputs are oversampled, so the block is fully synchronous to CLK7M. Each transaction is one command byte followed by one or more data bytes. Data bytes form an auto-incrementing burst.

---
 rtl/hu_spi_pkg.sv | 15 +
 rtl/hu_sync_edge.sv | 27 ++
 rtl/hu_spi_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hu_spi_pkg.sv
// Shared types and widths for the HULOGIC SPI responder.
package hu_spi_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned CMD_WR = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

endpackage

// File: rtl/hu_sync_edge.sv
// Multi-stage synchroniser with registered single-cycle rise/fall pulses.
module hu_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   // Top bit is the previous synchronised value used for edge detection.
   logic [STAGES:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[STAGES-1:0], d};
         rise <= sync[STAGES-1] & ~sync[STAGES];
         fall <= ~sync[STAGES-1] & sync[STAGES];
      end
   end

endmodule

// File: rtl/hu_spi_responder.sv
// SPI mode-0 responder bridging command/burst transactions onto a 16-register local bus.
module hu_spi_responder
   import hu_spi_pkg::*;
#(
   parameter logic [DATA_W-1:0] ID_BYTE     = 8'hA5,
   parameter int unsigned       SYNC_STAGES = 2
) (
   input  logic              CLK7M,
   input  logic              nRESET,
   input  logic              SPICLK,
   input  logic              MOSI,
   input  logic              nSPICS,
   output logic              MISO,
   output logic              MISO_oe,
   output logic [ADDR_W-1:0] loc_addr,
   output logic [DATA_W-1:0] loc_wdata,
   output logic              loc_wr,
   output logic              loc_rd,
   input  logic [DATA_W-1:0] loc_rdata,
   output logic              busy
);

   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   cs_rise;
   logic                   cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [DATA_W-1:0]      rx_nxt;

   state_t                 state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-1:0]      rx;
   logic [DATA_W-1:0]      tx;
   logic                   wr_mode;
   logic                   load_pend;

   hu_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
      .clk   (CLK7M),
      .rst_n (nRESET),
      .d     (SPICLK),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   // Resets to "selected" so a chip select held low across reset release is ignored.
   hu_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
      .clk   (CLK7M),
      .rst_n (nRESET),
      .d     (nSPICS),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   always_ff @(posedge CLK7M or negedge nRESET) begin
      if (!nRESET) mosi_sync <= '0;
      else         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
   end

   assign rx_nxt = {rx[DATA_W-2:0], mosi_sync[SYNC_STAGES-1]};

   always_ff @(posedge CLK7M or negedge nRESET) begin
      if (!nRESET) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx        <= '0;
         tx        <= '0;
         wr_mode   <= 1'b0;
         load_pend <= 1'b0;
         MISO      <= 1'b0;
         MISO_oe   <= 1'b0;
         loc_addr  <= '0;
         loc_wdata <= '0;
         loc_wr    <= 1'b0;
         loc_rd    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         loc_wr    <= 1'b0;
         loc_rd    <= 1'b0;
         load_pend <= loc_rd;

         // Address advances only after the write strobe has been seen at the old address.
         if (loc_wr) loc_addr <= loc_addr + ADDR_W'(1);

         if (load_pend) begin
            tx   <= loc_rdata;
            MISO <= loc_rdata[DATA_W-1];
         end

         if (state != ST_IDLE && cs_rise) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            load_pend <= 1'b0;
            MISO      <= 1'b0;
            MISO_oe   <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cs_fall) begin
                     state   <= ST_CMD;
                     bit_cnt <= '0;
                     tx      <= ID_BYTE;
                     MISO    <= ID_BYTE[DATA_W-1];
                     MISO_oe <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
               ST_CMD, ST_DATA: begin
                  if (sclk_rise) begin
                     rx      <= rx_nxt;
                     bit_cnt <= bit_cnt + CNT_W'(1);
                     if (bit_cnt == '1) begin
                        if (state == ST_CMD) begin
                           state    <= ST_DATA;
                           wr_mode  <= rx_nxt[CMD_WR];
                           loc_addr <= rx_nxt[ADDR_W-1:0];
                           if (rx_nxt[CMD_WR]) tx     <= rx_nxt;
                           else                loc_rd <= 1'b1;
                        end else if (wr_mode) begin
                           loc_wdata <= rx_nxt;
                           loc_wr    <= 1'b1;
                           tx        <= rx_nxt;
                        end else begin
                           loc_addr <= loc_addr + ADDR_W'(1);
                           loc_rd   <= 1'b1;
                        end
                     end
                  end else if (sclk_fall) begin
                     // At a byte boundary the freshly loaded MSB is presented without shifting.
                     if (bit_cnt == '0) begin
                        MISO <= tx[DATA_W-1];
                     end else begin
                        tx   <= {tx[DATA_W-2:0], 1'b0};
                        MISO <= tx[DATA_W-2];
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
